// File: rtl/huff_region_sched_if.sv
// Bundles the scheduler's config, serial-bit, decoder-bank and pair-output signals.
// slave = the scheduler itself; master = the surrounding parser/decoder-bank/requantizer side.
interface huff_region_sched_if #(
  parameter int IDX_W = 9
);
  logic                    start_i;
  logic [IDX_W-1:0]        big_values_i;
  logic [IDX_W-1:0]        region0_pairs_i;
  logic [IDX_W-1:0]        region1_pairs_i;
  logic [4:0]              table_sel0_i;
  logic [4:0]              table_sel1_i;
  logic [4:0]              table_sel2_i;
  logic                    bit_valid_i;
  logic                    bit_data_i;
  logic                    bit_ready_o;
  logic [4:0]              ht_sel_o;
  logic                    ht_clr_o;
  logic                    ht_axiiv_o;
  logic                    ht_axiid_o;
  logic                    ht_axiov_i;
  logic signed [15:0]      ht_x_i;
  logic signed [15:0]      ht_y_i;
  logic                    pair_valid_o;
  logic signed [15:0]      pair_x_o;
  logic signed [15:0]      pair_y_o;
  logic [IDX_W-1:0]        pair_idx_o;
  logic                    done_o;
  logic                    err_o;

  modport slave (
    input  start_i, big_values_i, region0_pairs_i, region1_pairs_i,
           table_sel0_i, table_sel1_i, table_sel2_i,
           bit_valid_i, bit_data_i, ht_axiov_i, ht_x_i, ht_y_i,
    output bit_ready_o, ht_sel_o, ht_clr_o, ht_axiiv_o, ht_axiid_o,
           pair_valid_o, pair_x_o, pair_y_o, pair_idx_o, done_o, err_o
  );

  modport master (
    output start_i, big_values_i, region0_pairs_i, region1_pairs_i,
           table_sel0_i, table_sel1_i, table_sel2_i,
           bit_valid_i, bit_data_i, ht_axiov_i, ht_x_i, ht_y_i,
    input  bit_ready_o, ht_sel_o, ht_clr_o, ht_axiiv_o, ht_axiid_o,
           pair_valid_o, pair_x_o, pair_y_o, pair_idx_o, done_o, err_o
  );
endinterface

// File: rtl/huff_region_sched.sv
// Walks the big_values region of one granule: picks the Huffman table per region,
// gates serial bits into the selected decoder and streams indexed (x,y) pairs out.
module huff_region_sched #(
  parameter int MAX_PAIRS = 288,
  parameter int IDX_W     = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  huff_region_sched_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SELECT,
    S_DECODE,
    S_ZERO,
    S_FIN
  } state_t;

  localparam logic [IDX_W-1:0] MAX_P = IDX_W'(MAX_PAIRS);

  state_t             state_q;
  logic [IDX_W-1:0]   big_q, b0_q, b1_q;
  logic [4:0]         tbl0_q, tbl1_q, tbl2_q;
  logic [IDX_W-1:0]   pair_cnt_q, pair_idx_q;
  logic [4:0]         ht_sel_q;
  logic               ht_clr_q, pair_valid_q, done_q, err_q;
  logic signed [15:0] pair_x_q, pair_y_q;

  logic [IDX_W-1:0]   b0_d, b1_d;
  logic [IDX_W:0]     sum01;
  logic [IDX_W-1:0]   cnt_inc;
  logic [4:0]         sel_cur, sel_inc;
  logic               at_end, at_bound, bad_cfg, in_decode;

  // Region bounds clamped to big_values; the extra adder bit keeps b0+region1 from wrapping.
  always_comb begin
    b0_d  = (bus.region0_pairs_i < bus.big_values_i) ? bus.region0_pairs_i : bus.big_values_i;
    sum01 = {1'b0, b0_d} + {1'b0, bus.region1_pairs_i};
    b1_d  = (sum01 < {1'b0, bus.big_values_i}) ? sum01[IDX_W-1:0] : bus.big_values_i;
  end

  assign cnt_inc  = pair_cnt_q + IDX_W'(1);
  assign at_end   = (cnt_inc == big_q);
  assign at_bound = (cnt_inc == b0_q) || (cnt_inc == b1_q);

  // Table lookup naturally skips empty regions: the first region whose bound exceeds the count wins.
  assign sel_cur = (pair_cnt_q < b0_q) ? tbl0_q : (pair_cnt_q < b1_q) ? tbl1_q : tbl2_q;
  assign sel_inc = (cnt_inc < b0_q) ? tbl0_q : (cnt_inc < b1_q) ? tbl1_q : tbl2_q;

  assign bad_cfg = (big_q > MAX_P)
                 || (tbl0_q == 5'd4) || (tbl0_q == 5'd14)
                 || (tbl1_q == 5'd4) || (tbl1_q == 5'd14)
                 || (tbl2_q == 5'd4) || (tbl2_q == 5'd14);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      big_q        <= '0;
      b0_q         <= '0;
      b1_q         <= '0;
      tbl0_q       <= '0;
      tbl1_q       <= '0;
      tbl2_q       <= '0;
      pair_cnt_q   <= '0;
      pair_idx_q   <= '0;
      ht_sel_q     <= '0;
      ht_clr_q     <= 1'b0;
      pair_valid_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      pair_x_q     <= '0;
      pair_y_q     <= '0;
    end else begin
      pair_valid_q <= 1'b0;
      done_q       <= 1'b0;
      ht_clr_q     <= 1'b0;
      if (bus.start_i) begin
        big_q      <= bus.big_values_i;
        b0_q       <= b0_d;
        b1_q       <= b1_d;
        tbl0_q     <= bus.table_sel0_i;
        tbl1_q     <= bus.table_sel1_i;
        tbl2_q     <= bus.table_sel2_i;
        pair_cnt_q <= '0;
        err_q      <= 1'b0;
        ht_clr_q   <= 1'b1;
        state_q    <= S_CHECK;
      end else begin
        unique case (state_q)
          S_IDLE: state_q <= S_IDLE;
          S_CHECK: begin
            if (bad_cfg) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else if (big_q == '0) begin
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              ht_sel_q <= sel_cur;
              ht_clr_q <= 1'b1;
              state_q  <= S_SELECT;
            end
          end
          S_SELECT: state_q <= (ht_sel_q == 5'd0) ? S_ZERO : S_DECODE;
          S_DECODE, S_ZERO: begin
            // ZERO emits a pair every cycle; DECODE only when the decoder reports one.
            if (state_q == S_ZERO || bus.ht_axiov_i) begin
              pair_valid_q <= 1'b1;
              pair_idx_q   <= pair_cnt_q;
              pair_x_q     <= (state_q == S_ZERO) ? 16'sd0 : bus.ht_x_i;
              pair_y_q     <= (state_q == S_ZERO) ? 16'sd0 : bus.ht_y_i;
              pair_cnt_q   <= cnt_inc;
              if (at_end) begin
                state_q <= S_FIN;
              end else if (at_bound) begin
                ht_sel_q <= sel_inc;
                ht_clr_q <= 1'b1;
                state_q  <= S_SELECT;
              end
            end
          end
          S_FIN: begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Bits are held back while the decoder presents a pair so none leaks into the next pair.
  assign in_decode      = (state_q == S_DECODE);
  assign bus.bit_ready_o  = in_decode & bus.bit_valid_i & ~bus.ht_axiov_i;
  assign bus.ht_axiiv_o   = in_decode & bus.bit_valid_i & ~bus.ht_axiov_i;
  assign bus.ht_axiid_o   = in_decode & bus.bit_data_i;
  assign bus.ht_clr_o     = ht_clr_q | (in_decode & bus.ht_axiov_i);
  assign bus.ht_sel_o     = ht_sel_q;
  assign bus.pair_valid_o = pair_valid_q;
  assign bus.pair_x_o     = pair_x_q;
  assign bus.pair_y_o     = pair_y_q;
  assign bus.pair_idx_o   = pair_idx_q;
  assign bus.done_o       = done_q;
  assign bus.err_o        = err_q;

endmodule
